// File: rtl/eth_mac_v3_pkg.sv
// Shared types and sizing for the ethernet_mac_v3 transmit frame buffer.
package eth_mac_v3_pkg;

  localparam int DEPTH    = 768;
  localparam int AW       = 10;
  localparam int LQ_DEPTH = 4;
  localparam int MAX_LEN  = 1536;
  localparam int LW       = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } tx_state_e;

  // Word pointer increment with explicit wrap at DEPTH-1 (DEPTH is not a power of two).
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    logic [AW-1:0] nxt;
    if (ptr == AW'(DEPTH - 1)) begin
      nxt = {AW{1'b0}};
    end else begin
      nxt = ptr + AW'(1);
    end
    return nxt;
  endfunction

  // Number of 32-bit words occupied by a frame of len bytes.
  function automatic logic [LW-1:0] len_words(input logic [LW-1:0] len);
    logic [LW-1:0] sum;
    sum = len + LW'(3);
    return sum >> 2;
  endfunction

endpackage

// File: rtl/eth_tx_dpram_768x32.sv
// 768x32 simple dual-port storage built from three 256x32 banks, 1-cycle read latency.
module eth_tx_dpram_768x32
  import eth_mac_v3_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [1:0] rd_bank_r;

  for (genvar b = 0; b < 3; b++) begin : g_bank
    logic [31:0] mem_r [0:255];
    logic [31:0] q_r;

    // One bank: write when the upper address bits select it, registered read.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr[AW-1:AW-2] == 2'(b))) begin
        mem_r[wr_addr[7:0]] <= wr_data;
      end
      if (rd_en) begin
        q_r <= mem_r[rd_addr[7:0]];
      end
    end
  end

  // Bank select follows the read by one cycle so it lines up with the bank output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_r <= 2'd0;
    end else if (rd_en) begin
      rd_bank_r <= rd_addr[AW-1:AW-2];
    end
  end

  // Output bank mux.
  always_comb begin
    case (rd_bank_r)
      2'd0:    rd_data = g_bank[0].q_r;
      2'd1:    rd_data = g_bank[1].q_r;
      2'd2:    rd_data = g_bank[2].q_r;
      default: rd_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/eth_mac_tx_frame_buf_v3.sv
// TX frame buffer: host pushes words and commits frame lengths, MAC pulls a byte
// stream over valid/ready. Circular word store, 4-entry length queue, read FSM.
module eth_mac_tx_frame_buf_v3
  import eth_mac_v3_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          frm_commit,
  input  logic [LW-1:0] frm_len,
  output logic [LW-1:0] free_words,
  output logic          lq_full,
  output logic          err_ovf,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_last,
  input  logic          tx_ready
);

  logic [AW-1:0] wp_r, rp_r;
  logic [LW-1:0] occ_r, occ_nxt_s, free_words_r;
  logic [LW-1:0] lq_mem_r [0:LQ_DEPTH-1];
  logic [1:0]    lq_wp_r, lq_rp_r;
  logic [2:0]    lq_cnt_r, lq_cnt_nxt_s;
  logic          lq_full_r, err_ovf_r;
  tx_state_e     state_r;
  logic [LW-1:0] cnt_r, fw_r, rd_left_r;
  logic [1:0]    idx_r;
  logic [31:0]   word_r, rd_data_s;
  logic          tx_valid_r, tx_last_r;
  logic [7:0]    tx_data_r;
  logic          wr_acc_s, wr_drop_s, commit_ok_s, commit_bad_s;
  logic          pop_s, hs_s, rel_s, word_end_s, rd_en_s;

  eth_tx_dpram_768x32 u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc_s),
    .wr_addr (wp_r),
    .wr_data (wr_data),
    .rd_en   (rd_en_s),
    .rd_addr (rp_r),
    .rd_data (rd_data_s)
  );

  // Request decode; the RAM read at rp_r is issued on pop and one word ahead while streaming.
  always_comb begin
    wr_acc_s     = wr_en && (occ_r != LW'(DEPTH));
    wr_drop_s    = wr_en && (occ_r == LW'(DEPTH));
    commit_ok_s  = frm_commit && !lq_full_r && (frm_len != 11'd0) && (frm_len <= LW'(MAX_LEN));
    commit_bad_s = frm_commit && !commit_ok_s;
    pop_s        = (state_r == IDLE) && (lq_cnt_r != 3'd0);
    hs_s         = (state_r == STREAM) && tx_valid_r && tx_ready;
    rel_s        = hs_s && (cnt_r == 11'd1);
    word_end_s   = hs_s && !rel_s && (idx_r == 2'd3);
    rd_en_s      = pop_s || (((state_r == FETCH) || word_end_s) && (rd_left_r != 11'd0));
    occ_nxt_s    = occ_r + {10'd0, wr_acc_s} - (rel_s ? fw_r : 11'd0);
    lq_cnt_nxt_s = lq_cnt_r + {2'd0, commit_ok_s} - {2'd0, pop_s};
  end

  // Write pointer, occupancy, length queue and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r         <= {AW{1'b0}};
      occ_r        <= 11'd0;
      free_words_r <= LW'(DEPTH);
      lq_wp_r      <= 2'd0;
      lq_rp_r      <= 2'd0;
      lq_cnt_r     <= 3'd0;
      lq_full_r    <= 1'b0;
      err_ovf_r    <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_mem_r[i] <= 11'd0;
      end
    end else begin
      if (wr_acc_s) begin
        wp_r <= ptr_next(wp_r);
      end
      occ_r        <= occ_nxt_s;
      free_words_r <= LW'(DEPTH) - occ_nxt_s;
      lq_cnt_r     <= lq_cnt_nxt_s;
      lq_full_r    <= (lq_cnt_nxt_s == 3'(LQ_DEPTH));
      if (commit_ok_s) begin
        lq_mem_r[lq_wp_r] <= frm_len;
        lq_wp_r           <= lq_wp_r + 2'd1;
      end
      if (pop_s) begin
        lq_rp_r <= lq_rp_r + 2'd1;
      end
      if (wr_drop_s || commit_bad_s) begin
        err_ovf_r <= 1'b1;
      end
    end
  end

  // Read FSM: pop length, fetch first word, then serialise bytes with one-word prefetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rp_r       <= {AW{1'b0}};
      cnt_r      <= 11'd0;
      fw_r       <= 11'd0;
      rd_left_r  <= 11'd0;
      idx_r      <= 2'd0;
      word_r     <= 32'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'd0;
      tx_last_r  <= 1'b0;
    end else begin
      if (rd_en_s) begin
        rp_r <= ptr_next(rp_r);
      end
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            cnt_r     <= lq_mem_r[lq_rp_r];
            fw_r      <= len_words(lq_mem_r[lq_rp_r]);
            rd_left_r <= len_words(lq_mem_r[lq_rp_r]) - 11'd1;
            state_r   <= FETCH;
          end
        end
        FETCH: begin
          word_r     <= rd_data_s;
          tx_data_r  <= rd_data_s[7:0];
          tx_last_r  <= (cnt_r == 11'd1);
          tx_valid_r <= 1'b1;
          idx_r      <= 2'd0;
          if (rd_left_r != 11'd0) begin
            rd_left_r <= rd_left_r - 11'd1;
          end
          state_r <= STREAM;
        end
        STREAM: begin
          if (rel_s) begin
            tx_valid_r <= 1'b0;
            tx_last_r  <= 1'b0;
            state_r    <= IDLE;
          end else if (hs_s) begin
            cnt_r     <= cnt_r - 11'd1;
            tx_last_r <= (cnt_r == 11'd2);
            idx_r     <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              // Prefetched word is already at the RAM output.
              word_r    <= rd_data_s;
              tx_data_r <= rd_data_s[7:0];
              if (rd_left_r != 11'd0) begin
                rd_left_r <= rd_left_r - 11'd1;
              end
            end else begin
              tx_data_r <= word_r[{idx_r + 2'd1, 3'd0} +: 8];
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign free_words = free_words_r;
  assign lq_full    = lq_full_r;
  assign err_ovf    = err_ovf_r;
  assign tx_valid   = tx_valid_r;
  assign tx_data    = tx_data_r;
  assign tx_last    = tx_last_r;

endmodule

// File: tb/tb_eth_mac_tx_frame_buf_v3.sv
// Directed self-checking bench for eth_mac_tx_frame_buf_v3; inputs driven and
// outputs sampled on the falling edge.
module tb_eth_mac_tx_frame_buf_v3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        frm_commit = 1'b0;
  logic [10:0] frm_len = 11'd0;
  logic [10:0] free_words;
  logic        lq_full, err_ovf, tx_valid, tx_last;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  eth_mac_tx_frame_buf_v3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .frm_commit (frm_commit),
    .frm_len    (frm_len),
    .free_words (free_words),
    .lq_full    (lq_full),
    .err_ovf    (err_ovf),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tx_ready = 1'b0; wr_en = 1'b0; frm_commit = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
  endtask

  task automatic wr_word(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic commit(input int len);
    frm_commit = 1'b1; frm_len = 11'(len);
    tick();
    frm_commit = 1'b0;
  endtask

  // Writes ceil(len/4) words whose byte k is base+k, and queues the expected bytes.
  task automatic put_words(input int len, input int base);
    logic [31:0] d;
    for (int w = 0; w < (len + 3) / 4; w++) begin
      for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'(base + 4*w + b);
      wr_word(d);
    end
    for (int i = 0; i < len; i++) exp_q.push_back(8'(base + i));
  endtask

  task automatic send_frame(input int len, input int base);
    put_words(len, base);
    commit(len);
  endtask

  // Receives n bytes; mode 0 holds tx_ready high, mode 1 drives ready 1,0,0,1,0,0...
  task automatic rx_frame(input int n, input int mode, input string tag);
    int got = 0;
    int k = 0;
    int first = -1;
    bit stall = 1'b0;
    logic [7:0] pd = 8'd0;
    logic pl = 1'b0;
    logic [7:0] e;
    while (got < n && k < 8*n + 64) begin
      tx_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (stall) begin
        chk({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_hold_data"}, 32'(tx_data), 32'(pd));
        chk({tag, "_hold_last"}, 32'(tx_last), 32'(pl));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 8'h00;
        chk({tag, "_data"}, 32'(tx_data), 32'(e));
        chk({tag, "_last"}, 32'(tx_last), 32'(got == n - 1));
        if (first < 0) first = k;
        got++;
        if (got == n && mode == 0) chk({tag, "_span"}, 32'(k - first), 32'(n - 1));
      end
      stall = tx_valid && !tx_ready;
      pd = tx_data;
      pl = tx_last;
      tick();
      k++;
    end
    tx_ready = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_free", 32'(free_words), 32'd768);
    chk("rst_lq_full", 32'(lq_full), 32'd0);
    chk("rst_err", 32'(err_ovf), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_last", 32'(tx_last), 32'd0);

    // Single 5-byte frame with commit-to-valid latency.
    wr_word(32'h44332211);
    wr_word(32'h00000055);
    chk("single_free_wr", 32'(free_words), 32'd766);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    commit(5);
    chk("lat_n1", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_n2", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_n3", 32'(tx_valid), 32'd1);
    rx_frame(5, 0, "single");
    chk("single_free_rel", 32'(free_words), 32'd768);

    // Backpressure on an 8-byte frame.
    send_frame(8, 8'hA0);
    rx_frame(8, 1, "bp");
    chk("bp_free", 32'(free_words), 32'd768);

    // Advance both pointers from 4 to 766, then a frame that wraps to word 0.
    send_frame(1524, 8'h00);
    send_frame(1524, 8'h33);
    rx_frame(1524, 0, "adv_a");
    rx_frame(1524, 0, "adv_b");
    send_frame(16, 8'hC0);
    chk("wrap_free", 32'(free_words), 32'd764);
    rx_frame(16, 0, "wrap");
    chk("wrap_free_rel", 32'(free_words), 32'd768);
    send_frame(4, 8'hE0);
    rx_frame(4, 0, "post_wrap");
    chk("err_clear", 32'(err_ovf), 32'd0);

    // Fill all 768 words, push one more, then drain two maximum-length frames.
    put_words(1536, 8'h10);
    put_words(1536, 8'h90);
    chk("full_free", 32'(free_words), 32'd0);
    wr_word(32'hDEADBEEF);
    chk("ovf_err", 32'(err_ovf), 32'd1);
    chk("ovf_free", 32'(free_words), 32'd0);
    commit(1536);
    commit(1536);
    rx_frame(1536, 0, "ovf_a");
    rx_frame(1536, 0, "ovf_b");
    chk("ovf_free_rel", 32'(free_words), 32'd768);

    // One frame is popped into the streamer at once, so five commits fill the queue.
    do_reset();
    chk("rst2_err", 32'(err_ovf), 32'd0);
    for (int f = 0; f < 5; f++) send_frame(4, 8'h40 + 16*f);
    chk("lq_full_set", 32'(lq_full), 32'd1);
    commit(4);
    chk("lq_rej_err", 32'(err_ovf), 32'd1);
    chk("lq_full_hold", 32'(lq_full), 32'd1);
    for (int f = 0; f < 5; f++) begin
      chk("lq_start", 32'(tx_valid), 32'd1);
      rx_frame(4, 0, "lq");
      chk("lq_gap1", 32'(tx_valid), 32'd0);
      tick();
      chk("lq_gap2", 32'(tx_valid), 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("lq_no_sixth", 32'(tx_valid), 32'd0);
      tick();
    end
    chk("lq_free", 32'(free_words), 32'd768);
    chk("lq_empty", 32'(lq_full), 32'd0);

    // Zero and oversize lengths are rejected.
    do_reset();
    commit(0);
    chk("len0_err", 32'(err_ovf), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("len0_novalid", 32'(tx_valid), 32'd0);
      tick();
    end
    do_reset();
    commit(1537);
    chk("len1537_err", 32'(err_ovf), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("len1537_novalid", 32'(tx_valid), 32'd0);
      tick();
    end

    // Reset while byte 3 of a 60-byte frame is presented.
    do_reset();
    send_frame(60, 8'h01);
    tx_ready = 1'b1;
    begin
      int hs = 0;
      for (int k = 0; k < 20 && hs < 3; k++) begin
        if (tx_valid) hs++;
        tick();
      end
    end
    tx_ready = 1'b0;
    chk("mid_valid", 32'(tx_valid), 32'd1);
    chk("mid_byte3", 32'(tx_data), 32'h04);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_free", 32'(free_words), 32'd768);
    chk("mid_rst_data", 32'(tx_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_post_valid", 32'(tx_valid), 32'd0);
      chk("mid_post_free", 32'(free_words), 32'd768);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
